// File: rtl/multicycle_shifter.sv
// multicycle_shifter: iterative SLL/SRL/SRA unit that shifts STEP bit positions per clock.
//
// Optional build macro: SHIFTER_ROTATE_EN
//   defined   -> op=2'b10 performs rotate-right (ROR/RORI)
//   undefined -> op=2'b10 is decoded as SRL (zero fill)
//
// Ports:
//   clk      core clock, rising-edge active
//   reset    asynchronous active-high reset
//   start    request; accepted only while idle or done
//   op       2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 ROR or SRL (see macro)
//   operand  value to shift
//   shamt    shift amount
//   busy     high while shifting
//   done     one-cycle completion pulse
//   result   working register; valid while done is high, held until the next accepted start
module multicycle_shifter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  // One extra bit so STEP == XLEN is representable.
  localparam logic [SHAMT_W:0] StepC = (SHAMT_W + 1)'(STEP);
`ifdef SHIFTER_ROTATE_EN
  localparam logic [SHAMT_W:0] XlenC = (SHAMT_W + 1)'(XLEN);
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;

  logic [SHAMT_W:0]   step_amt;
  logic [XLEN-1:0]    srl_val;
  logic [XLEN-1:0]    fill_mask;
  logic [XLEN-1:0]    shifted;
`ifdef SHIFTER_ROTATE_EN
  logic [SHAMT_W:0]   rot_amt;
`endif

  // Single step of the datapath: shift by min(STEP, remaining).
  always_comb begin
    step_amt  = ({1'b0, rem_q} < StepC) ? {1'b0, rem_q} : StepC;
    srl_val   = work_q >> step_amt;
    fill_mask = ~({XLEN{1'b1}} >> step_amt);
`ifdef SHIFTER_ROTATE_EN
    // step_amt is never zero while shifting, so rot_amt stays below XLEN.
    rot_amt   = XlenC - step_amt;
`endif
    shifted   = srl_val;
    unique case (op_q)
      2'b00: shifted = work_q << step_amt;
      2'b01: shifted = srl_val;
      2'b11: shifted = srl_val | (sign_q ? fill_mask : '0);
`ifdef SHIFTER_ROTATE_EN
      2'b10: shifted = srl_val | (work_q << rot_amt);
`else
      2'b10: shifted = srl_val;
`endif
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          work_d  = operand;
          op_d    = op;
          rem_d   = shamt;
          sign_d  = operand[XLEN-1];
          state_d = (shamt == '0) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        work_d = shifted;
        rem_d  = rem_q - step_amt[SHAMT_W-1:0];
        if (rem_d == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = work_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed bench for multicycle_shifter: one STEP=1 and one STEP=4 instance, XLEN=32.
module tb_multicycle_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_shifter #(.XLEN(32), .STEP(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start1),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .busy    (busy1),
    .done    (done1),
    .result  (result1)
  );

  multicycle_shifter #(.XLEN(32), .STEP(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .start   (start4),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .busy    (busy4),
    .done    (done4),
    .result  (result4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start an op on the selected instance (0: STEP=1, 1: STEP=4) and count edges until done.
  task automatic run_op(input logic sel, input logic [1:0] o, input logic [31:0] a,
                        input logic [4:0] sh, output int edges, output logic [31:0] res);
    @(negedge clk);
    op = o; operand = a; shamt = sh;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
    operand = 32'hDEAD_BEEF; shamt = 5'd7; op = 2'b00;
    edges = 1;
    while (!(sel ? done4 : done1) && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res = sel ? result4 : result1;
  endtask

  int          edges;
  logic [31:0] res;

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = 2'b00; operand = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy1}, 32'd0);
    check("reset_done", {31'd0, done1}, 32'd0);
    check("reset_result", result1, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 2'b01, 32'd42, 5'd1, edges, res);
    check("srl1_edges", edges, 32'd2);
    check("srl1_result", res, 32'd21);
    run_op(1'b0, 2'b01, 32'd42, 5'd2, edges, res);
    check("srl2_result", res, 32'd10);
    run_op(1'b0, 2'b01, 32'd42, 5'd3, edges, res);
    check("srl3_edges", edges, 32'd4);
    check("srl3_result", res, 32'd5);

    run_op(1'b0, 2'b11, 32'h8000_0000, 5'd31, edges, res);
    check("sra31_edges", edges, 32'd32);
    check("sra31_result", res, 32'hFFFF_FFFF);
    run_op(1'b0, 2'b01, 32'h8000_0000, 5'd31, edges, res);
    check("srl31_result", res, 32'h0000_0001);
    run_op(1'b0, 2'b11, 32'h4000_0000, 5'd30, edges, res);
    check("sra_pos_result", res, 32'h0000_0001);
    run_op(1'b0, 2'b00, 32'h0000_00F1, 5'd8, edges, res);
    check("sll8_result", res, 32'h0000_F100);

    run_op(1'b1, 2'b00, 32'd1, 5'd13, edges, res);
    check("s4_sll13_edges", edges, 32'd5);
    check("s4_sll13_result", res, 32'h0000_2000);
    run_op(1'b1, 2'b00, 32'h1234_5678, 5'd0, edges, res);
    check("s4_sh0_edges", edges, 32'd1);
    check("s4_sh0_result", res, 32'h1234_5678);
    run_op(1'b1, 2'b11, 32'hF000_0000, 5'd5, edges, res);
    check("s4_sra5_edges", edges, 32'd3);
    check("s4_sra5_result", res, 32'hFF80_0000);

    run_op(1'b0, 2'b10, 32'h0000_0001, 5'd4, edges, res);
`ifdef SHIFTER_ROTATE_EN
    check("op10_result", res, 32'h1000_0000);
`else
    check("op10_result", res, 32'h0000_0000);
`endif
    run_op(1'b1, 2'b10, 32'h0000_0001, 5'd4, edges, res);
`ifdef SHIFTER_ROTATE_EN
    check("s4_op10_result", res, 32'h1000_0000);
`else
    check("s4_op10_result", res, 32'h0000_0000);
`endif

    // Start during SHIFT must be ignored.
    @(negedge clk);
    op = 2'b01; operand = 32'h0000_0100; shamt = 5'd4; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    check("busy_mid", {31'd0, busy1}, 32'd1);
    op = 2'b00; operand = 32'h0000_FFFF; shamt = 5'd1; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    edges = 3;
    while (!done1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("ign_edges", edges, 32'd5);
    check("ign_result", result1, 32'h0000_0010);
    @(posedge clk);
    #1;
    check("ign_done_once", {31'd0, done1}, 32'd0);
    check("ign_busy_after", {31'd0, busy1}, 32'd0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd20; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_done", {31'd0, done1}, 32'd0);
    check("mid_rst_result", result1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 2'b01, 32'd42, 5'd1, edges, res);
    check("post_rst_edges", edges, 32'd2);
    check("post_rst_result", res, 32'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
